// File: rtl/decode_pkg.sv
// Shared opcode/func codes, strobe bundle and field-offset helpers
// for the instruction decode stage.
package decode_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_R   = 1;
    localparam int OP_I   = 2;
    localparam int OP_S   = 3;
    localparam int OP_B   = 4;
    localparam int OP_J   = 5;
    localparam int OP_X   = 6;
    localparam int OP_ILL = 7;

    localparam int F_ST  = 0;
    localparam int F_LD  = 1;
    localparam int F_BEQ = 0;
    localparam int F_BNE = 1;
    localparam int F_FFT = 2;

    typedef struct packed {
        logic write_reg;
        logic jump;
        logic beq;
        logic bne;
        logic st;
        logic ld;
        logic fft;
        logic illegal;
    } ctrl_t;

    function automatic int rd_lsb(int opw);
        return opw;
    endfunction

    function automatic int rs1_lsb(int opw, int regw);
        return opw + regw;
    endfunction

    function automatic int rs2_lsb(int opw, int regw);
        return opw + 2 * regw;
    endfunction

    function automatic int func_lsb(int opw, int regw);
        return opw + 3 * regw;
    endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Pure combinational instruction word -> decoded bundle table.
// Unused fields and strobes are driven to zero.
module idu_decode_comb
    import decode_pkg::*;
#(
    parameter int OPW   = 3,
    parameter int REGW  = 4,
    parameter int FUNCW = 4,
    parameter int XLEN  = 32
) (
    input  logic [OPW+3*REGW+FUNCW-1:0] instr,
    output logic [OPW-1:0]              opcode,
    output logic [FUNCW-1:0]            func,
    output logic [REGW-1:0]             rd,
    output logic [REGW-1:0]             rs1,
    output logic [REGW-1:0]             rs2,
    output logic [XLEN-1:0]             imm_extended,
    output logic [REGW-1:0]             imm_addr,
    output logic [REGW-1:0]             imm_branch,
    output ctrl_t                       ctrl
);

    logic [OPW-1:0]   op_f;
    logic [REGW-1:0]  rd_f;
    logic [REGW-1:0]  rs1_f;
    logic [REGW-1:0]  rs2_f;
    logic [FUNCW-1:0] fn_f;

    assign op_f  = instr[OPW-1:0];
    assign rd_f  = instr[rd_lsb(OPW) +: REGW];
    assign rs1_f = instr[rs1_lsb(OPW, REGW) +: REGW];
    assign rs2_f = instr[rs2_lsb(OPW, REGW) +: REGW];
    assign fn_f  = instr[func_lsb(OPW, REGW) +: FUNCW];

    always_comb begin
        opcode       = op_f;
        func         = fn_f;
        rd           = '0;
        rs1          = '0;
        rs2          = '0;
        imm_extended = '0;
        imm_addr     = '0;
        imm_branch   = '0;
        ctrl         = '0;
        unique case (1'b1)
            op_f == OPW'(OP_NOP): begin
            end
            op_f == OPW'(OP_R): begin
                rd             = rd_f;
                rs1            = rs1_f;
                rs2            = rs2_f;
                ctrl.write_reg = 1'b1;
            end
            op_f == OPW'(OP_I): begin
                rs1 = rs1_f;
                imm_extended = {{(XLEN-REGW){rs2_f[REGW-1]}}, rs2_f};
                // func 0 / all-ones update the source register in place
                rd = (fn_f == '0 || fn_f == '1) ? rs1_f : rd_f;
                ctrl.write_reg = 1'b1;
            end
            op_f == OPW'(OP_S): begin
                if (fn_f == FUNCW'(F_ST)) begin
                    ctrl.st  = 1'b1;
                    rs1      = rs1_f;
                    imm_addr = rd_f;
                end else if (fn_f == FUNCW'(F_LD)) begin
                    ctrl.ld        = 1'b1;
                    ctrl.write_reg = 1'b1;
                    rd             = rs1_f;
                    imm_addr       = rd_f;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op_f == OPW'(OP_B): begin
                rs1        = rs1_f;
                rs2        = rs2_f;
                imm_branch = rd_f;
                if (fn_f == FUNCW'(F_BEQ))
                    ctrl.beq = 1'b1;
                else if (fn_f == FUNCW'(F_BNE))
                    ctrl.bne = 1'b1;
                else
                    ctrl.illegal = 1'b1;
            end
            op_f == OPW'(OP_J): begin
                ctrl.jump = 1'b1;
                imm_addr  = rs2_f;
            end
            op_f == OPW'(OP_X): begin
                rs1      = rs1_f;
                imm_addr = rd_f;
                if (fn_f == FUNCW'(F_FFT)) begin
                    ctrl.fft = 1'b1;
                end else begin
                    ctrl.write_reg = 1'b1;
                    rd             = rd_f;
                end
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: valid/ready pipeline register with flush and illegal flag.
// Define DECODE_LOADUSE_STALL_EN to add the load-use bubble.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int OPW   = 3,
    parameter int REGW  = 4,
    parameter int FUNCW = 4,
    parameter int XLEN  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPW+3*REGW+FUNCW-1:0] instruction_code,
    input  logic                        branch_flush,
    input  logic                        flush_jump,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPW-1:0]              opcode,
    output logic [FUNCW-1:0]            func,
    output logic [REGW-1:0]             rd,
    output logic [REGW-1:0]             rs1,
    output logic [REGW-1:0]             rs2,
    output logic [XLEN-1:0]             imm_extended,
    output logic [REGW-1:0]             imm_addr,
    output logic [REGW-1:0]             imm_branch,
    output logic                        write_reg,
    output logic                        jump,
    output logic                        beq,
    output logic                        bne,
    output logic                        st,
    output logic                        ld,
    output logic                        fft,
    output logic                        illegal
);

    logic             flush;
    logic             can_take;
    logic             hazard;
    logic             accept;
    logic [OPW-1:0]   d_opcode;
    logic [FUNCW-1:0] d_func;
    logic [REGW-1:0]  d_rd;
    logic [REGW-1:0]  d_rs1;
    logic [REGW-1:0]  d_rs2;
    logic [XLEN-1:0]  d_imm;
    logic [REGW-1:0]  d_imm_addr;
    logic [REGW-1:0]  d_imm_branch;
    ctrl_t            d_ctrl;
    ctrl_t            q_ctrl;

    idu_decode_comb #(
        .OPW   (OPW),
        .REGW  (REGW),
        .FUNCW (FUNCW),
        .XLEN  (XLEN)
    ) u_dec (
        .instr        (instruction_code),
        .opcode       (d_opcode),
        .func         (d_func),
        .rd           (d_rd),
        .rs1          (d_rs1),
        .rs2          (d_rs2),
        .imm_extended (d_imm),
        .imm_addr     (d_imm_addr),
        .imm_branch   (d_imm_branch),
        .ctrl         (d_ctrl)
    );

    assign flush    = branch_flush | flush_jump;
    assign can_take = !flush && (!out_valid || out_ready);
    assign in_ready = can_take && !hazard;
    assign accept   = in_valid && in_ready;

`ifdef DECODE_LOADUSE_STALL_EN
    logic            last_ld_vld;
    logic [REGW-1:0] last_ld_rd;
    logic            rd_match;

    // decoded rs1/rs2 are zero when the format does not read them
    assign rd_match = (last_ld_rd != '0) &&
                      (d_rs1 == last_ld_rd || d_rs2 == last_ld_rd);
    assign hazard   = last_ld_vld && in_valid && can_take && rd_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ld_vld <= 1'b0;
            last_ld_rd  <= '0;
        end else if (flush) begin
            last_ld_vld <= 1'b0;
        end else if (accept) begin
            last_ld_vld <= d_ctrl.ld;
            last_ld_rd  <= d_rd;
        end else if (hazard) begin
            last_ld_vld <= 1'b0;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            opcode       <= '0;
            func         <= '0;
            rd           <= '0;
            rs1          <= '0;
            rs2          <= '0;
            imm_extended <= '0;
            imm_addr     <= '0;
            imm_branch   <= '0;
            q_ctrl       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            q_ctrl    <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            opcode       <= d_opcode;
            func         <= d_func;
            rd           <= d_rd;
            rs1          <= d_rs1;
            rs2          <= d_rs2;
            imm_extended <= d_imm;
            imm_addr     <= d_imm_addr;
            imm_branch   <= d_imm_branch;
            q_ctrl       <= d_ctrl;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign write_reg = q_ctrl.write_reg;
    assign jump      = q_ctrl.jump;
    assign beq       = q_ctrl.beq;
    assign bne       = q_ctrl.bne;
    assign st        = q_ctrl.st;
    assign ld        = q_ctrl.ld;
    assign fft       = q_ctrl.fft;
    assign illegal   = q_ctrl.illegal;

endmodule
